// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its controller/PLL side.
// master = PLL/controller side (drives locked, retry_clr); slave = sequencer.
interface pll_lock_sequencer_if;
  logic       locked;
  logic       retry_clr;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_cnt;

  modport master (
    output locked, retry_clr,
    input  pll_rst, sys_rst_n, ready, fault, lock_loss_cnt
  );

  modport slave (
    input  locked, retry_clr,
    output pll_rst, sys_rst_n, ready, fault, lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on refclk: pulses PLL reset, qualifies lock, releases system reset.
// Optional RUN-state lock-loss debounce enabled by defining PLL_SEQ_LOSS_FILTER_EN.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RETRY_MAX           = 3,
  parameter int LOSS_FILTER_CYCLES  = 4
) (
  input  logic                  i_refclk,
  input  logic                  i_rst_n,
  pll_lock_sequencer_if.slave   pll_if
);

  localparam int M0   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int M1   = (M0 > LOCK_STABLE_CYCLES) ? M0 : LOCK_STABLE_CYCLES;
  localparam int CMAX = (M1 > LOSS_FILTER_CYCLES) ? M1 : LOSS_FILTER_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int RW   = $clog2(RETRY_MAX + 1);

  localparam logic [CW-1:0] C_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_ST_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] C_RETRY    = RW'(RETRY_MAX);
`ifdef PLL_SEQ_LOSS_FILTER_EN
  localparam logic [CW-1:0] C_LF_LAST  = CW'(LOSS_FILTER_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [RW-1:0] r_retry, w_retry_nxt;
  logic [7:0]    r_llc, w_llc_nxt;
  logic          r_sync1, r_locked_s;
  logic          r_pll_rst, r_sys_rst_n, r_ready, r_fault;
  logic          w_loss;

  always_ff @(posedge i_refclk) begin
    if (!i_rst_n) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_llc       <= '0;
      r_sync1     <= 1'b0;
      r_locked_s  <= 1'b0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_llc       <= w_llc_nxt;
      r_sync1     <= pll_if.locked;
      r_locked_s  <= r_sync1;
      // Outputs decode the next state so they change on the same edge as the state.
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
      r_sys_rst_n <= (w_state_nxt == S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      r_fault     <= (w_state_nxt == S_FAULT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_retry_nxt = r_retry;
    w_llc_nxt   = r_llc;
    w_loss      = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == C_RST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock seen on the timeout cycle takes precedence over consuming a retry.
        if (r_locked_s) begin
          w_state_nxt = S_STABILIZE;
        end else if (r_cnt == C_TO_LAST) begin
          w_retry_nxt = r_retry + RW'(1);
          w_state_nxt = (w_retry_nxt == C_RETRY) ? S_FAULT : S_RESET_PLL;
        end
      end
      S_STABILIZE: begin
        if (!r_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (r_cnt == C_ST_LAST) begin
          w_state_nxt = S_RUN;
          w_retry_nxt = '0;
        end
      end
      S_RUN: begin
`ifdef PLL_SEQ_LOSS_FILTER_EN
        // Counter tracks the current run of consecutive low samples.
        if (!r_locked_s) begin
          if (r_cnt == C_LF_LAST) w_loss = 1'b1;
        end else begin
          w_cnt_nxt = '0;
        end
`else
        w_cnt_nxt = '0;
        if (!r_locked_s) w_loss = 1'b1;
`endif
        if (w_loss) begin
          w_state_nxt = S_RESET_PLL;
          w_llc_nxt   = (r_llc == 8'hFF) ? r_llc : r_llc + 8'd1;
        end
      end
      S_FAULT: begin
        w_cnt_nxt = r_cnt;
        if (pll_if.retry_clr) begin
          w_state_nxt = S_RESET_PLL;
          w_retry_nxt = '0;
        end
      end
      default: w_state_nxt = S_RESET_PLL;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  assign pll_if.pll_rst       = r_pll_rst;
  assign pll_if.sys_rst_n     = r_sys_rst_n;
  assign pll_if.ready         = r_ready;
  assign pll_if.fault         = r_fault;
  assign pll_if.lock_loss_cnt = r_llc;

endmodule
